// File: rtl/pll_div_pkg.sv
// pll_div_pkg: shared constants for the pulse-swallow divider slice.
//   - default P/S widths and reset ratio (P=8, S=1 -> N_total = 25)
//   - dual-modulus prescaler moduli and the minimum legal P
//   - prescaler mod encoding and an N_total helper for benches
package pll_div_pkg;

    localparam int unsigned DEF_PW = 6;
    localparam int unsigned DEF_SW = 6;
    localparam int unsigned DEF_P  = 8;
    localparam int unsigned DEF_S  = 1;

    localparam int unsigned PRESCALER_LO = 3;
    localparam int unsigned PRESCALER_HI = 4;
    localparam int unsigned P_MIN        = 2;

    // Level driven onto the prescaler mod input.
    typedef enum logic {
        MOD_DIV3 = 1'b0,
        MOD_DIV4 = 1'b1
    } psc_mod_e;

    // Division from the prescaler input clock to the frame output:
    // S cycles at /4 plus (P-S) cycles at /3.
    function automatic int unsigned n_total(input int unsigned p, input int unsigned s);
        return PRESCALER_LO * p + (PRESCALER_HI - PRESCALER_LO) * s;
    endfunction

endpackage

// File: rtl/ps_down_counter.sv
// ps_down_counter: loadable down-counter used for both the main (P) and
// swallow (S) counters.
//   clk_i       clock
//   rst_ni      synchronous active-low reset (loads RST_VAL)
//   load_i      load load_val_i this cycle (has priority over decrement)
//   load_val_i  reload value
//   dec_en_i    decrement enable
//   zero_o      current count is zero
//   nxt_zero_o  count after the coming edge will be zero (feeds registered outputs)
module ps_down_counter #(
    parameter int unsigned    W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_en_i,
    output logic         zero_o,
    output logic         nxt_zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_en_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign nxt_zero_o = (cnt_d == '0);

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// pulse_swallow_ctrl: programmable P/S pulse-swallow counter behind the
// divBy3or4 prescaler. Total division N_total = 3*P + S.
//   clk_in     prescaler clk_out (single clock domain)
//   rst_n      synchronous active-low reset
//   cfg_p      requested P (legal: P >= 2)
//   cfg_s      requested S (legal: S <= P)
//   cfg_valid  request valid
//   cfg_ready  pending slot empty, request can be accepted
//   cfg_err    one-cycle pulse after an illegal request is rejected
//   mod_out    prescaler mod: 1 = divide by 4, 0 = divide by 3
//   div_out    frame output to the phase detector
// Build option: PULSE_SWALLOW_SQUARE_EN turns div_out into a toggle at each
// frame wrap (square wave, period 2*P); otherwise it is a one-cycle wrap pulse.
module pulse_swallow_ctrl
    import pll_div_pkg::*;
#(
    parameter int unsigned PW    = DEF_PW,
    parameter int unsigned SW    = DEF_SW,
    parameter int unsigned P_DEF = DEF_P,
    parameter int unsigned S_DEF = DEF_S
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic [PW-1:0] cfg_p,
    input  logic [SW-1:0] cfg_s,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          mod_out,
    output logic          div_out
);

    localparam int unsigned MW = (PW > SW) ? PW : SW;
    localparam logic [MW-1:0] P_MIN_W = MW'(P_MIN);

    logic [PW-1:0] act_p_q, act_p_d, pend_p_q, pend_p_d;
    logic [SW-1:0] act_s_q, act_s_d, pend_s_q, pend_s_d;
    logic          pend_full_q, pend_full_d;
    logic          err_q, err_d;
    psc_mod_e      mod_q, mod_d;
    logic          div_q, div_d;

    logic [MW-1:0] req_p_x, req_s_x;
    logic          req_legal;
    logic          xfer;
    logic          wrap;
    logic          p_nxt_zero;
    logic          s_zero, s_nxt_zero;
    logic [PW-1:0] sel_p;
    logic [SW-1:0] sel_s;

    assign req_p_x   = MW'(cfg_p);
    assign req_s_x   = MW'(cfg_s);
    assign req_legal = (req_p_x >= P_MIN_W) && (req_s_x <= req_p_x);
    assign xfer      = cfg_valid && !pend_full_q;

    // Values the counters reload with at wrap: a full pending slot takes
    // effect at this wrap, before the reload.
    assign sel_p = pend_full_q ? pend_p_q : act_p_q;
    assign sel_s = pend_full_q ? pend_s_q : act_s_q;

    ps_down_counter #(
        .W       (PW),
        .RST_VAL (PW'(P_DEF - 1))
    ) u_p_cnt (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (wrap),
        .load_val_i (sel_p - PW'(1)),
        .dec_en_i   (1'b1),
        .zero_o     (wrap),
        .nxt_zero_o (p_nxt_zero)
    );

    // The swallow counter parks at zero for the rest of the frame.
    ps_down_counter #(
        .W       (SW),
        .RST_VAL (SW'(S_DEF))
    ) u_s_cnt (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (wrap),
        .load_val_i (sel_s),
        .dec_en_i   (!s_zero),
        .zero_o     (s_zero),
        .nxt_zero_o (s_nxt_zero)
    );

    always_comb begin
        act_p_d     = act_p_q;
        act_s_d     = act_s_q;
        pend_p_d    = pend_p_q;
        pend_s_d    = pend_s_q;
        pend_full_d = pend_full_q;
        err_d       = xfer && !req_legal;

        if (wrap && pend_full_q) begin
            act_p_d     = pend_p_q;
            act_s_d     = pend_s_q;
            pend_full_d = 1'b0;
        end
        // A request in the wrap cycle lands in the (empty) slot and waits
        // for the following wrap.
        if (xfer && req_legal) begin
            pend_p_d    = cfg_p;
            pend_s_d    = cfg_s;
            pend_full_d = 1'b1;
        end

        // Registered outputs track the counter state after the coming edge.
        mod_d = s_nxt_zero ? MOD_DIV3 : MOD_DIV4;
`ifdef PULSE_SWALLOW_SQUARE_EN
        div_d = div_q ^ wrap;
`else
        div_d = p_nxt_zero;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            act_p_q     <= PW'(P_DEF);
            act_s_q     <= SW'(S_DEF);
            pend_p_q    <= '0;
            pend_s_q    <= '0;
            pend_full_q <= 1'b0;
            err_q       <= 1'b0;
            mod_q       <= (S_DEF != 0) ? MOD_DIV4 : MOD_DIV3;
            div_q       <= 1'b0;
        end else begin
            act_p_q     <= act_p_d;
            act_s_q     <= act_s_d;
            pend_p_q    <= pend_p_d;
            pend_s_q    <= pend_s_d;
            pend_full_q <= pend_full_d;
            err_q       <= err_d;
            mod_q       <= mod_d;
            div_q       <= div_d;
        end
    end

    assign cfg_ready = !pend_full_q;
    assign cfg_err   = err_q;
    assign mod_out   = mod_q;
    assign div_out   = div_q;

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// tb_pulse_swallow_ctrl: self-checking bench for pulse_swallow_ctrl.
// A frame-position model predicts all outputs every cycle through a
// scoreboard queue; a request table and a few directed sequences check
// handshake results and measured division ratios.
module tb_pulse_swallow_ctrl;
    import pll_div_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] cfg_p = '0;
    logic [5:0] cfg_s = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, cfg_err, mod_out, div_out;

    always #5 clk = ~clk;

    pulse_swallow_ctrl #(
        .PW    (6),
        .SW    (6),
        .P_DEF (8),
        .S_DEF (1)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .cfg_p     (cfg_p),
        .cfg_s     (cfg_s),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .mod_out   (mod_out),
        .div_out   (div_out)
    );

    typedef struct {
        logic mod;
        logic div;
        logic rdy;
        logic err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int unsigned p;
        int unsigned s;
        bit          legal;
        int unsigned ratio;
    } vec_t;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    // Reference model: position within the frame counting up from 0.
    int unsigned m_pos, m_P, m_S, m_pP, m_pS;
    bit          m_pend, m_err, m_tog;

    logic s_mod, s_div, s_rdy, s_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit xfer, legal, wrap;
        if (!rst_n) begin
            m_pos = 0; m_P = 8; m_S = 1; m_pend = 0; m_err = 0; m_tog = 0;
            m_pP = 0; m_pS = 0;
        end else begin
            xfer  = cfg_valid && !m_pend;
            legal = (cfg_p >= 2) && (cfg_s <= cfg_p);
            m_err = xfer && !legal;
            wrap  = (m_pos == m_P - 1);
            if (wrap) begin
                m_tog = !m_tog;
                m_pos = 0;
                if (m_pend) begin
                    m_P = m_pP; m_S = m_pS; m_pend = 0;
                end
            end else begin
                m_pos++;
            end
            if (xfer && legal) begin
                m_pend = 1; m_pP = cfg_p; m_pS = cfg_s;
            end
        end
    endtask

    // One clock: update model at the edge, queue the prediction, clear the
    // one-shot request, then compare on the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.mod = (m_pos < m_S);
`ifdef PULSE_SWALLOW_SQUARE_EN
        e.div = m_tog;
`else
        e.div = (m_pos == m_P - 1);
`endif
        e.rdy = !m_pend;
        e.err = m_err;
        sb_q.push_back(e);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        s_mod = mod_out; s_div = div_out; s_rdy = cfg_ready; s_err = cfg_err;
        e = sb_q.pop_front();
        check("sb_mod_out", s_mod, e.mod);
        check("sb_div_out", s_div, e.div);
        check("sb_cfg_ready", s_rdy, e.rdy);
        check("sb_cfg_err", s_err, e.err);
    endtask

    task automatic request(input int unsigned p, input int unsigned s);
        cfg_p = 6'(p); cfg_s = 6'(s); cfg_valid = 1'b1;
        cycle();
    endtask

    task automatic wait_wrap();
        int unsigned n = 0;
        do begin
            cycle(); n++;
        end while (!s_div && n < 300);
        if (!s_div) check("wrap_timeout", 0, 1);
    endtask

    // Length and mod-high count of the frame after the current wrap sample.
    task automatic frame_len(output int unsigned len, output int unsigned hi);
        len = 0; hi = 0;
        do begin
            cycle(); len++; hi += s_mod;
        end while (!s_div && len < 300);
        if (!s_div) check("frame_timeout", 0, 1);
    endtask

    vec_t vecs[8];
    int unsigned L, H;

    initial begin
        vecs[0] = '{10, 4, 1'b1, 34};
        vecs[1] = '{5,  6, 1'b0, 34};
        vecs[2] = '{1,  0, 1'b0, 34};
        vecs[3] = '{2,  2, 1'b1, 8};
        vecs[4] = '{2,  0, 1'b1, 6};
        vecs[5] = '{0,  0, 1'b0, 6};
        vecs[6] = '{63, 62, 1'b1, 251};
        vecs[7] = '{8,  1, 1'b1, 25};

        rst_n = 1'b0;
        cycle();
        cycle();
        check("rst_mod_out", s_mod, 1);
        check("rst_div_out", s_div, 0);
        check("rst_cfg_ready", s_rdy, 1);
        check("rst_cfg_err", s_err, 0);
        rst_n = 1'b1;

`ifndef PULSE_SWALLOW_SQUARE_EN
        wait_wrap();
        frame_len(L, H);
        check("def_len", L, 8);
        check("def_mod_hi", H, 1);
        check("def_ratio", 3 * L + H, 25);

        foreach (vecs[i]) begin
            cycle(); cycle();
            request(vecs[i].p, vecs[i].s);
            check("tbl_err", s_err, !vecs[i].legal);
            check("tbl_ready", s_rdy, !vecs[i].legal);
            wait_wrap();
            wait_wrap();
            frame_len(L, H);
            check("tbl_ratio", 3 * L + H, vecs[i].ratio);
            if (vecs[i].legal) begin
                check("tbl_len", L, vecs[i].p);
                check("tbl_ntotal", 3 * L + H, n_total(vecs[i].p, vecs[i].s));
            end
            check("tbl_ready_after", s_rdy, 1);
        end

        // Request in the wrap cycle: next reload still old, then 4/0.
        wait_wrap();
        cfg_p = 6'd4; cfg_s = 6'd0; cfg_valid = 1'b1;
        frame_len(L, H);
        check("wrapreq_old_len", L, 8);
        check("wrapreq_old_hi", H, 1);
        frame_len(L, H);
        check("wrapreq_new_len", L, 4);
        check("wrapreq_new_hi", H, 0);

        // Reset mid-frame with a request pending.
        cycle();
        request(10, 4);
        check("pend_ready_low", s_rdy, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_mod_out", s_mod, 1);
        check("midrst_div_out", s_div, 0);
        check("midrst_ready", s_rdy, 1);
        wait_wrap();
        frame_len(L, H);
        check("midrst_len", L, 8);
        check("midrst_hi", H, 1);
        frame_len(L, H);
        check("midrst_len2", L, 8);
`else
        request(6, 0);
        wait_wrap();
        for (int k = 0; k < 3; k++) begin
            logic prev;
            int unsigned n;
            prev = s_div; n = 0;
            do begin
                cycle(); n++;
            end while (s_div == prev && n < 100);
            if (k > 0) check("sq_half_period", n, 6);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
